// File: rtl/stream_upsizer.sv
// -----------------------------------------------------------------------------
// stream_upsizer
//   Packs RATIO consecutive IN_WIDTH-bit input beats into one
//   IN_WIDTH*RATIO-bit output word. The first beat of a word lands in the
//   lowest lane. A word is emitted early when in_last arrives; its unfilled
//   upper lanes read as zero. The output stage is a single register with
//   valid/ready handshake. A completing beat may swap into the output register
//   in the same cycle that the previous word drains, so there is no bubble.
//
// Parameters
//   IN_WIDTH  input beat width in bits (>= 1)
//   RATIO     input beats per output word (>= 1); RATIO=1 is a registered
//             pass-through
//
// Optional feature (compile-time macro)
//   STREAM_UPSIZER_KEEP_EN  adds port out_keep, one bit per written lane, and
//                           its per-lane storage. Undefined: both are absent.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset; clears all state
//   in_valid   upstream beat valid
//   in_ready   beat accepted this cycle (when in_valid is also high)
//   in_data    beat payload, IN_WIDTH bits
//   in_last    beat ends a packet; forces the current word to complete
//   out_valid  packed word valid (downstream fifo w_valid)
//   out_ready  downstream accept (downstream fifo w_ready)
//   out_data   packed word, IN_WIDTH*RATIO bits, beat k in lane k
//   out_last   word ends a packet
//   out_keep   (STREAM_UPSIZER_KEEP_EN only) lane k was written
// -----------------------------------------------------------------------------
module stream_upsizer #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_WIDTH-1:0]          in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IN_WIDTH*RATIO-1:0]    out_data,
  output logic                         out_last
`ifdef STREAM_UPSIZER_KEEP_EN
  ,
  output logic [RATIO-1:0]             out_keep
`endif
);

  localparam int OUT_W = IN_WIDTH * RATIO;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  if (RATIO < 1 || IN_WIDTH < 1) begin : g_bad_params
    $fatal(1, "stream_upsizer: RATIO and IN_WIDTH must both be >= 1");
  end

  // Assembly stage: lane counter and partially built word
  logic [CNT_W-1:0] cnt_p0;
  logic [OUT_W-1:0] lanes_p0;

  // Output stage: registered word presented downstream
  logic             vld_p1;
  logic [OUT_W-1:0] data_p1;
  logic             last_p1;

  logic             completes;
  logic             stalled;
  logic             in_fire;
  logic [OUT_W-1:0] lanes_nxt;

`ifdef STREAM_UPSIZER_KEEP_EN
  logic [RATIO-1:0] keep_p0;
  logic [RATIO-1:0] keep_p1;
  logic [RATIO-1:0] keep_nxt;
`endif

  // The presented beat closes the word if it fills the top lane or ends a packet.
  assign completes = (cnt_p0 == LAST_LANE) || in_last;
  assign stalled   = vld_p1 && !out_ready;
  // Only a completing beat needs the output register, so only it can be
  // blocked by a stalled output.
  assign in_ready  = !(completes && stalled);
  assign in_fire   = in_valid && in_ready;

  // Merge the incoming beat into the lane selected by the counter. Lanes
  // above the counter are still zero because the assembly register is
  // cleared whenever a word completes.
  always_comb begin
    lanes_nxt = lanes_p0;
`ifdef STREAM_UPSIZER_KEEP_EN
    keep_nxt  = keep_p0;
`endif
    for (int k = 0; k < RATIO; k++) begin
      if (cnt_p0 == CNT_W'(k)) begin
        lanes_nxt[k*IN_WIDTH +: IN_WIDTH] = in_data;
`ifdef STREAM_UPSIZER_KEEP_EN
        keep_nxt[k] = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0   <= '0;
      lanes_p0 <= '0;
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      last_p1  <= 1'b0;
`ifdef STREAM_UPSIZER_KEEP_EN
      keep_p0  <= '0;
      keep_p1  <= '0;
`endif
    end else begin
      if (in_fire) begin
        if (completes) begin
          cnt_p0   <= '0;
          lanes_p0 <= '0;
`ifdef STREAM_UPSIZER_KEEP_EN
          keep_p0  <= '0;
`endif
        end else begin
          cnt_p0   <= cnt_p0 + CNT_W'(1);
          lanes_p0 <= lanes_nxt;
`ifdef STREAM_UPSIZER_KEEP_EN
          keep_p0  <= keep_nxt;
`endif
        end
      end

      // Assembly -> output register; a completing beat overwrites a word
      // that is draining this same cycle.
      if (in_fire && completes) begin
        vld_p1  <= 1'b1;
        data_p1 <= lanes_nxt;
        last_p1 <= in_last;
`ifdef STREAM_UPSIZER_KEEP_EN
        keep_p1 <= keep_nxt;
`endif
      end else if (out_ready) begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_last  = last_p1;
`ifdef STREAM_UPSIZER_KEEP_EN
  assign out_keep  = keep_p1;
`endif

endmodule

// File: tb/tb_stream_upsizer.sv
// -----------------------------------------------------------------------------
// tb_stream_upsizer
//   Self-checking bench for stream_upsizer (IN_WIDTH=8, RATIO=4). A reference
//   model keeps the accepted beats of the current word in a queue and the
//   pending output word as a value; every cycle it predicts in_ready,
//   out_valid and the presented word. Directed sequences are followed by
//   randomized traffic.
// -----------------------------------------------------------------------------
module tb_stream_upsizer;

  localparam int IW = 8;
  localparam int R  = 4;
  localparam int WW = IW * R;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [WW-1:0] out_data;
  logic          out_last;
`ifdef STREAM_UPSIZER_KEEP_EN
  logic [R-1:0]  out_keep;
`endif

  stream_upsizer #(.IN_WIDTH(IW), .RATIO(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
`ifdef STREAM_UPSIZER_KEEP_EN
    ,
    .out_keep  (out_keep)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [IW-1:0] cur[$];
  bit            pend = 1'b0;
  logic [WW-1:0] pend_data = '0;
  bit            pend_last = 1'b0;
  logic [R-1:0]  pend_keep = '0;

  // One clock cycle: drive inputs, check predictions, then advance the model.
  task automatic step(input bit v, input logic [IW-1:0] d, input bit l, input bit ordy);
    bit comp, exp_rdy, fire_in, fire_out;
    logic [WW-1:0] w;
    @(negedge clk);
    in_valid = v; in_data = d; in_last = l; out_ready = ordy;
    #1;
    comp    = (cur.size() == R - 1) || l;
    exp_rdy = !(comp && pend && !ordy);
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, pend);
    if (pend) begin
      check("out_data", out_data, pend_data);
      check("out_last", out_last, pend_last);
`ifdef STREAM_UPSIZER_KEEP_EN
      check("out_keep", out_keep, pend_keep);
`endif
    end
    fire_in  = v && exp_rdy;
    fire_out = pend && ordy;
    @(posedge clk);
    if (fire_in) cur.push_back(d);
    if (fire_in && comp) begin
      w = '0;
      foreach (cur[i]) w = w | (WW'(cur[i]) << (IW * i));
      pend_data = w;
      pend_last = l;
      pend_keep = R'((1 << cur.size()) - 1);
      pend      = 1'b1;
      cur.delete();
    end else if (fire_out) begin
      pend = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_last", out_last, 1'b0);
`ifdef STREAM_UPSIZER_KEEP_EN
    check("rst_out_keep", out_keep, '0);
`endif
    cur.delete();
    pend = 1'b0; pend_data = '0; pend_last = 1'b0; pend_keep = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();

    // Full word
    step(1, 8'h11, 0, 1); step(1, 8'h22, 0, 1);
    step(1, 8'h33, 0, 1); step(1, 8'h44, 0, 1);
    #1;
    check("full_data", out_data, 32'h44332211);
    check("full_last", out_last, 1'b0);
`ifdef STREAM_UPSIZER_KEEP_EN
    check("full_keep", out_keep, 4'hF);
`endif

    // Partial word closed by in_last
    step(1, 8'hAA, 0, 1); step(1, 8'hBB, 1, 1);
    #1;
    check("part_data", out_data, 32'h0000BBAA);
    check("part_last", out_last, 1'b1);
`ifdef STREAM_UPSIZER_KEEP_EN
    check("part_keep", out_keep, 4'h3);
`endif

    // Single-beat packet
    step(1, 8'h5A, 1, 1);
    #1;
    check("single_data", out_data, 32'h0000005A);
    check("single_last", out_last, 1'b1);
`ifdef STREAM_UPSIZER_KEEP_EN
    check("single_keep", out_keep, 4'h1);
`endif

    // Stalled output: non-completing beats still accepted, beat 4 held back
    step(1, 8'h01, 0, 1); step(1, 8'h02, 0, 1);
    step(1, 8'h03, 0, 1); step(1, 8'h04, 0, 0);
    step(1, 8'hA1, 0, 0); step(1, 8'hA2, 0, 0); step(1, 8'hA3, 0, 0);
    step(1, 8'hA4, 0, 0); step(1, 8'hA4, 0, 0);
    #1;
    check("stall_in_ready", in_ready, 1'b0);
    check("stall_hold_data", out_data, 32'h04030201);
    step(1, 8'hA4, 0, 1);
    #1;
    check("swap_valid", out_valid, 1'b1);
    check("swap_data", out_data, 32'hA4A3A2A1);

    // Eight back-to-back beats
    for (int i = 0; i < 8; i++) step(1, IW'(8'h10 + i), 0, 1);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);

    // Reset in the middle of a word
    step(1, 8'hE1, 0, 1); step(1, 8'hE2, 0, 1);
    do_reset();
    step(1, 8'h01, 0, 1); step(1, 8'h02, 0, 1);
    step(1, 8'h03, 0, 1); step(1, 8'h04, 0, 1);
    #1;
    check("post_rst_data", out_data, 32'h04030201);
    step(0, 8'h00, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, IW'($urandom), $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) != 0);
    end
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stream_upsizer.md
STREAM_UPSIZER -- requirements
Module: stream_upsizer

Interface
REQ-001 The block SHALL have parameter IN_WIDTH, default 8, giving the input beat width in bits.
REQ-002 The block SHALL have parameter RATIO, default 4, giving the number of input beats packed into one output word.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, indicating the upstream beat is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit, indicating the block accepts the beat.
REQ-007 The block SHALL have port in_data, input, IN_WIDTH bits, carrying the beat payload.
REQ-008 The block SHALL have port in_last, input, 1 bit, marking the final beat of a packet.
REQ-009 The block SHALL have port out_valid, output, 1 bit, indicating the output word is valid; it feeds the downstream fifo w_valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit, the downstream accept signal (fifo w_ready).
REQ-011 The block SHALL have port out_data, output, IN_WIDTH*RATIO bits, carrying the packed word.
REQ-012 The block SHALL have port out_last, output, 1 bit, set when the word ends a packet.
REQ-013 The block SHALL have port out_keep, output, RATIO bits, one bit per filled lane; it exists only under STREAM_UPSIZER_KEEP_EN.

Function
REQ-014 A transfer SHALL occur on a side only in a cycle where that side's valid and ready are both high.
REQ-015 Beat k of a word (k = 0..RATIO-1) SHALL occupy out_data bits [k*IN_WIDTH +: IN_WIDTH]; the first beat goes in the lowest lane.
REQ-016 A lane counter (0..RATIO-1) SHALL advance on each input transfer and SHALL return to 0 when a word completes.
REQ-017 A word SHALL complete on an input transfer when the counter equals RATIO-1 or in_last=1.
REQ-018 A completed word SHALL load the output register, with out_valid=1 on the next cycle (latency 1 cycle from the completing beat).
REQ-019 Unfilled lanes of a partial word SHALL read as zero.
REQ-020 out_last SHALL equal in_last of the completing beat.
REQ-021 out_valid, out_data, out_last and out_keep SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 in_ready SHALL be 1 unless the presented beat would complete a word while out_valid=1 and out_ready=0; in_ready may depend combinationally on out_ready and in_last.
REQ-023 Non-completing beats SHALL be accepted while the output register is stalled.
REQ-024 When an output transfer and a completing input transfer coincide, the new word SHALL replace the old one with no bubble.
REQ-025 When the output register drains and no completing beat arrives in the same cycle, out_valid SHALL fall to 0 on the next cycle.
REQ-026 With RATIO=1, every beat SHALL complete a word, giving a one-stage registered pass-through.
REQ-027 Elaboration SHALL fatal if RATIO<1 or IN_WIDTH<1.

Reset
REQ-028 While rst=1 at a clock edge, the counter and assembly lanes SHALL clear to 0.
REQ-029 While rst=1 at a clock edge, out_valid, out_data, out_last and out_keep SHALL clear to 0.
REQ-030 Reset SHALL discard any partially assembled word and any pending output word.
REQ-031 in_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-032 With STREAM_UPSIZER_KEEP_EN defined, port out_keep SHALL exist, and bit k SHALL be 1 if and only if lane k was written in the emitted word (e.g. 2 beats give 4'b0011).
REQ-033 Without STREAM_UPSIZER_KEEP_EN, port out_keep and its storage SHALL be absent; all other behaviour SHALL be identical.

Verification (IN_WIDTH=8, RATIO=4, KEEP_EN defined)
REQ-034 Beats 11,22,33,44 (hex), in_last=0, out_ready=1 -> one cycle after beat 4: out_data=0x44332211, out_last=0, out_keep=4'hF.
REQ-035 Beats AA then BB with in_last=1 -> out_data=0x0000BBAA, out_last=1, out_keep=4'h3.
REQ-036 A single beat 5A with in_last=1 -> out_data=0x0000005A, out_last=1, out_keep=4'h1; the counter is back at 0.
REQ-037 Word pending with out_ready=0, then 4 more beats -> first 3 accepted, in_ready=0 on beat 4 until out_ready=1, then same-cycle swap and the new word appears the next cycle.
REQ-038 Eight back-to-back beats with out_ready=1 -> in_ready stays 1 throughout, and exactly two words are emitted.
REQ-039 rst pulsed after 2 beats, then beats 01..04 -> out_valid=0 after reset, then the next word is 0x04030201.
